// File: rtl/alu_pkg.sv
// alu_pkg: shared defaults and state encoding for the sequential adder
package alu_pkg;

    localparam int DEF_WIDTH = 20;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SLICE-bit adder with carry-out and carry into the MSB
module adder_slice
    import alu_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_s,
    output logic             o_cout,
    output logic             o_cmsb
);

    // sum bit MSB is a^b^carry_in, so the carry into the MSB falls out of the sum
    always_comb begin
        {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
        o_cmsb        = o_s[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];
    end

endmodule

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle adder processing SLICE bits per clock
module seq_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_accept;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_s;
    logic             w_cout;
    logic             w_cmsb;

    assign w_sa = r_a[r_cnt*SLICE +: SLICE];
    assign w_sb = r_b[r_cnt*SLICE +: SLICE];
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

    adder_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // handshake outputs and next state; DONE accepts a new start like IDLE
    always_comb begin
        ready    = (r_state != RUN);
        done     = (r_state == DONE);
        w_accept = start && ready;
        w_next   = r_state;
        if (w_accept)             w_next = RUN;
        else if (r_state == RUN)  w_next = (r_cnt == LAST) ? DONE : RUN;
        else                      w_next = IDLE;
    end

    // operand capture and one slice of addition per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= cin;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            r_sum[r_cnt*SLICE +: SLICE] <= w_s;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_cout <= w_cout;
                r_ovf  <= w_cmsb ^ w_cout;
            end
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// tb_seq_adder: self-checking bench for seq_adder (vectors, random model, corner sequences)
module tb_seq_adder;

    localparam int W   = 20;
    localparam int N   = 5;
    localparam int LAT = N + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    seq_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference: full-width arithmetic, overflow when like-signed operands give an unlike-signed sum
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    task automatic scramble();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    // counts negedges after the start cycle until done; done follows the accepting edge by N edges
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W-1:0] es, input logic eco, input logic eov);
        int n;
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        @(negedge clk);
        start = 1'b0;
        scramble();
        chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_res"}, {11'd0, eov, eco, es}, {11'd0, ovf, cout, sum});
        @(negedge clk);
        chk({tag, "_after"}, {10'd0, done, ready, ovf, cout, sum}, {10'd0, 1'b0, 1'b1, eov, eco, es});
    endtask

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra, rb, a2, b2;
        logic         rc, c2;
        int           n;
        bit           seen;

        vecs[0] = '{20'h12345, 20'h0ABCD, 1'b0, 20'h1CF12, 1'b0, 1'b0};
        vecs[1] = '{20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1, 1'b0};
        vecs[2] = '{20'h7FFFF, 20'h00001, 1'b0, 20'h80000, 1'b0, 1'b1};
        vecs[3] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1, 1'b1};
        vecs[4] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1, 1'b0};
        vecs[5] = '{20'h00000, 20'h00000, 1'b0, 20'h00000, 1'b0, 1'b0};
        vecs[6] = '{20'h55555, 20'hAAAAA, 1'b1, 20'h00000, 1'b1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", {10'd0, done, ready, ovf, cout, sum}, {10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 20'd0});
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                                          vecs[i].s, vecs[i].co, vecs[i].ov);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (i % 5 == 0) rb = ~ra;
            m = model(ra, rb, rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, m[W-1:0], m[W], m[W+1]);
        end

        ra = 20'h7A5C3;
        rb = 20'h3B1F0;
        rc = 1'b1;
        a2 = 20'hC0001;
        b2 = 20'hBFFFF;
        c2 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a = ra;
        b = rb;
        cin = rc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) scramble();
        end while (!done && n < 20);
        chk("b2b_lat1", n, LAT);
        m = model(ra, rb, rc);
        chk("b2b_res1", {11'd0, ovf, cout, sum}, {11'd0, m[W+1], m[W], m[W-1:0]});
        a = a2;
        b = b2;
        cin = c2;
        @(negedge clk);
        start = 1'b0;
        scramble();
        chk("b2b_rerun", {30'd0, done, ready}, 32'd0);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat2", n, LAT);
        m = model(a2, b2, c2);
        chk("b2b_res2", {11'd0, ovf, cout, sum}, {11'd0, m[W+1], m[W], m[W-1:0]});

        @(negedge clk);
        start = 1'b1;
        a = 20'hFFFFF;
        b = 20'hFFFFF;
        cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_state", {10'd0, done, ready, ovf, cout, sum}, {10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 20'd0});
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", {31'd0, seen}, 32'd0);
        run_op("post_abort", 20'h00001, 20'h00001, 1'b0, 20'h00002, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        a = 20'h12345;
        b = 20'h11111;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            if (done || !ready) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_start_ignored", {31'd0, seen}, 32'd0);
        chk("rst_start_sum", {12'd0, sum}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
